// File: rtl/pic_priority_resolver.sv
// 8259-style priority resolver: fixed or rotating priority over 8 requests,
// two-pulse INTA acknowledge, and the in-service register up to EOI.
module pic_priority_resolver #(
  parameter logic [2:0] SPURIOUS_LVL = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta,
  input  logic       eoi,
  input  logic       seoi,
  input  logic       set_prio,
  input  logic [2:0] cmd_lvl,
  input  logic       rotate,
  input  logic       aeoi,
  output logic       int_req,
  output logic [7:0] clr_irr,
  output logic [2:0] vec_lvl,
  output logic       vec_valid,
  output logic [7:0] isr,
  output logic [2:0] lowest_lvl
);

  typedef enum logic {S_IDLE, S_ACK2} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_int_req, w_int_req_nxt;
  logic [7:0] r_clr_irr, w_clr_irr_nxt;
  logic [2:0] r_vec_lvl, w_vec_lvl_nxt;
  logic       r_vec_valid, w_vec_valid_nxt;
  logic [7:0] r_isr, w_isr_nxt;
  logic [2:0] r_lowest, w_lowest_nxt;
  logic       r_spur, w_spur_nxt;

  logic [7:0] w_cand;
  logic       w_cand_any, w_isr_any, w_request;
  logic [2:0] w_win, w_win_rank, w_top, w_top_rank;
  logic [7:0] w_inta_set, w_aeoi_clr, w_cmd_clr;
  logic       w_aeoi_rot, w_l_from_cmd;
  logic [2:0] w_cmd_l;

  assign w_cand = irr & ~imr;

  // Walk levels from rank 0 (just above L) downward; first hit wins.
  always_comb begin
    logic [2:0] lvl;
    w_cand_any = 1'b0;
    w_win      = 3'd0;
    w_win_rank = 3'd0;
    w_isr_any  = 1'b0;
    w_top      = 3'd0;
    w_top_rank = 3'd0;
    for (int k = 0; k < 8; k++) begin
      lvl = r_lowest + 3'd1 + 3'(k);
      if (!w_cand_any && w_cand[lvl]) begin
        w_cand_any = 1'b1;
        w_win      = lvl;
        w_win_rank = 3'(k);
      end
      if (!w_isr_any && r_isr[lvl]) begin
        w_isr_any  = 1'b1;
        w_top      = lvl;
        w_top_rank = 3'(k);
      end
    end
  end

  assign w_request = w_cand_any && (!w_isr_any || (w_win_rank < w_top_rank));

  always_comb begin
    w_state_nxt     = r_state;
    w_int_req_nxt   = 1'b0;
    w_clr_irr_nxt   = 8'h00;
    w_vec_lvl_nxt   = r_vec_lvl;
    w_vec_valid_nxt = 1'b0;
    w_spur_nxt      = r_spur;
    w_inta_set      = 8'h00;
    w_aeoi_clr      = 8'h00;
    w_aeoi_rot      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_int_req_nxt = w_request;
        if (inta) begin
          w_int_req_nxt = 1'b0;
          w_state_nxt   = S_ACK2;
          if (w_cand_any) begin
            w_inta_set    = 8'h01 << w_win;
            w_clr_irr_nxt = 8'h01 << w_win;
            w_vec_lvl_nxt = w_win;
            w_spur_nxt    = 1'b0;
          end else begin
            w_vec_lvl_nxt = SPURIOUS_LVL;
            w_spur_nxt    = 1'b1;
          end
        end
      end
      S_ACK2: begin
        if (inta) begin
          w_vec_valid_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
          if (aeoi && !r_spur) begin
            w_aeoi_clr = 8'h01 << r_vec_lvl;
            w_aeoi_rot = rotate;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command decode: seoi beats eoi beats set_prio; losers are dropped.
  always_comb begin
    w_cmd_clr    = 8'h00;
    w_l_from_cmd = 1'b0;
    w_cmd_l      = cmd_lvl;
    if (seoi) begin
      w_cmd_clr    = 8'h01 << cmd_lvl;
      w_l_from_cmd = rotate;
    end else if (eoi) begin
      if (w_isr_any) begin
        w_cmd_clr    = 8'h01 << w_top;
        w_l_from_cmd = rotate;
        w_cmd_l      = w_top;
      end
    end else if (set_prio) begin
      w_l_from_cmd = 1'b1;
    end
  end

  assign w_isr_nxt    = (r_isr & ~w_cmd_clr & ~w_aeoi_clr) | w_inta_set;
  assign w_lowest_nxt = w_l_from_cmd ? w_cmd_l : (w_aeoi_rot ? r_vec_lvl : r_lowest);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_req   <= 1'b0;
      r_clr_irr   <= 8'h00;
      r_vec_lvl   <= 3'd0;
      r_vec_valid <= 1'b0;
      r_isr       <= 8'h00;
      r_lowest    <= 3'd7;
      r_spur      <= 1'b0;
    end else begin
      r_int_req   <= w_int_req_nxt;
      r_clr_irr   <= w_clr_irr_nxt;
      r_vec_lvl   <= w_vec_lvl_nxt;
      r_vec_valid <= w_vec_valid_nxt;
      r_isr       <= w_isr_nxt;
      r_lowest    <= w_lowest_nxt;
      r_spur      <= w_spur_nxt;
    end
  end

  assign int_req    = r_int_req;
  assign clr_irr    = r_clr_irr;
  assign vec_lvl    = r_vec_lvl;
  assign vec_valid  = r_vec_valid;
  assign isr        = r_isr;
  assign lowest_lvl = r_lowest;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver: a per-cycle vector table plus
// hand-written reset-during-acknowledge sequences.
module tb_pic_priority_resolver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irr, imr;
  logic       inta, eoi, seoi, set_prio, rotate, aeoi;
  logic [2:0] cmd_lvl;
  logic       int_req, vec_valid;
  logic [7:0] clr_irr, isr;
  logic [2:0] vec_lvl, lowest_lvl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pic_priority_resolver #(.SPURIOUS_LVL(3'd7)) dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .inta(inta), .eoi(eoi),
    .seoi(seoi), .set_prio(set_prio), .cmd_lvl(cmd_lvl), .rotate(rotate),
    .aeoi(aeoi), .int_req(int_req), .clr_irr(clr_irr), .vec_lvl(vec_lvl),
    .vec_valid(vec_valid), .isr(isr), .lowest_lvl(lowest_lvl)
  );

  typedef struct packed {
    logic [7:0] irr;
    logic [7:0] imr;
    logic       inta;
    logic       eoi;
    logic       seoi;
    logic       sp;
    logic [2:0] cmd;
    logic       rot;
    logic       aeoi;
    logic       e_int;
    logic [7:0] e_clr;
    logic [2:0] e_vl;
    logic       e_vv;
    logic [7:0] e_isr;
    logic [2:0] e_low;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic idle_inputs();
    irr = 8'h00; imr = 8'h00; inta = 1'b0; eoi = 1'b0; seoi = 1'b0;
    set_prio = 1'b0; cmd_lvl = 3'd0; rotate = 1'b0; aeoi = 1'b0;
  endtask

  task automatic check_all(input int idx, input logic e_int, input logic [7:0] e_clr,
                           input logic [2:0] e_vl, input logic e_vv, input logic [7:0] e_isr,
                           input logic [2:0] e_low);
    chk("int_req",    idx, {7'd0, int_req},   {7'd0, e_int});
    chk("clr_irr",    idx, clr_irr,           e_clr);
    chk("vec_lvl",    idx, {5'd0, vec_lvl},   {5'd0, e_vl});
    chk("vec_valid",  idx, {7'd0, vec_valid}, {7'd0, e_vv});
    chk("isr",        idx, isr,               e_isr);
    chk("lowest_lvl", idx, {5'd0, lowest_lvl}, {5'd0, e_low});
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    irr = v.irr; imr = v.imr; inta = v.inta; eoi = v.eoi; seoi = v.seoi;
    set_prio = v.sp; cmd_lvl = v.cmd; rotate = v.rot; aeoi = v.aeoi;
    @(posedge clk);
    #1;
    check_all(idx, v.e_int, v.e_clr, v.e_vl, v.e_vv, v.e_isr, v.e_low);
  endtask

  initial begin
    //              irr    imr    inta eoi  seoi sp   cmd   rot  aeoi | int  clr    vl    vv   isr    low
    tbl[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7};
    tbl[1]  = '{8'h24, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7};
    tbl[2]  = '{8'h24, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h04, 3'd2, 1'b0, 8'h04, 3'd7};
    tbl[3]  = '{8'h20, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 1'b1, 8'h04, 3'd7};
    tbl[4]  = '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 8'h04, 3'd7};
    tbl[5]  = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 1'b0, 8'h04, 3'd7};
    tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 8'h00, 3'd2};
    tbl[7]  = '{8'h09, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 1'b0, 8'h00, 3'd2};
    tbl[8]  = '{8'h09, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0, 8'h08, 3'd2};
    tbl[9]  = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 8'h08, 3'd2};
    tbl[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 3'd2};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 1'b0, 8'h00, 3'd2};
    tbl[12] = '{8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 1'b1, 8'h00, 3'd2};
    tbl[13] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 1'b0, 8'h00, 3'd4};
    tbl[14] = '{8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00, 3'd7, 1'b0, 8'h00, 3'd4};
    tbl[15] = '{8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h80, 3'd7, 1'b0, 8'h80, 3'd4};
    tbl[16] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd7, 1'b1, 8'h00, 3'd4};
    tbl[17] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00, 3'd7, 1'b0, 8'h00, 3'd4};
    tbl[18] = '{8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h02, 3'd1, 1'b0, 8'h02, 3'd4};
    tbl[19] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1, 8'h00, 3'd1};
    tbl[20] = '{8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0, 8'h10, 3'd1};
    tbl[21] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 1'b1, 8'h10, 3'd1};
    tbl[22] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 8'h00, 3'd1};
    tbl[23] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 8'h00, 3'd6};
    tbl[24] = '{8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd4, 1'b0, 8'h00, 3'd6};
    tbl[25] = '{8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'h80, 3'd7, 1'b0, 8'h80, 3'd7};
    tbl[26] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 1'b1, 8'h80, 3'd7};
    tbl[27] = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd7, 1'b0, 8'h80, 3'd7};
    tbl[28] = '{8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd7, 1'b0, 8'h80, 3'd7};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all(100, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) apply(tbl[i], i);

    // Reset asserted between the two INTA pulses of an AEOI acknowledge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all(200, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7);
    @(negedge clk);
    rst_n = 1'b1;
    apply('{8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1,
            1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7}, 201);
    apply('{8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1,
            1'b0, 8'h80, 3'd7, 1'b0, 8'h80, 3'd7}, 202);
    @(negedge clk);
    inta = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all(203, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd7);
    @(negedge clk);
    rst_n = 1'b1;
    // After reset this INTA is a first pulse again: no vec_valid.
    apply('{8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1,
            1'b0, 8'h80, 3'd7, 1'b0, 8'h80, 3'd7}, 204);
    apply('{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1,
            1'b0, 8'h00, 3'd7, 1'b1, 8'h00, 3'd7}, 205);
    apply('{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0,
            1'b0, 8'h00, 3'd7, 1'b0, 8'h00, 3'd7}, 206);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
